// File: rtl/requant_pack.sv
// requant_pack: requantizes signed 16-bit lanes to saturated int8 and packs 8 per output word.
// Define REQUANT_ROUND_EN to round half up before the arithmetic shift.
module requant_pack #(
    parameter int N_OUT_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    input  logic [15:0] scale,
    input  logic [4:0]  shift,
    output logic        write_en_bar2,
    output logic [63:0] data_in_bar2,
    output logic [31:0] addr_bar2,
    input  logic [63:0] data_out_bar2,
    output logic        write_en_bar3,
    output logic [63:0] data_in_bar3,
    output logic [31:0] addr_bar3,
    input  logic [63:0] data_out_bar3
);
    localparam int KW = (N_OUT_WORDS > 1) ? $clog2(N_OUT_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, WR, DONE} state_t;

    state_t          r_state, w_next;
    logic [KW-1:0]   r_k;
    logic            r_start, r_start_d;
    logic [15:0]     r_scale;
    logic [4:0]      r_shift;
    logic [63:0]     r_w0, r_w1, w_pack;
    logic            w_edge, w_launch, w_last, w_unused;
    logic signed [32:0] w_rnd;

    assign w_unused = ^data_out_bar3;
    assign w_edge   = r_start & ~r_start_d;
    assign w_launch = w_edge & (r_state == IDLE || r_state == DONE);
    assign w_last   = r_k == KW'(N_OUT_WORDS - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_edge) w_next = RD0;
            RD0:        w_next = RD1;
            RD1:        w_next = CAP;
            CAP:        w_next = WR;
            WR:         w_next = w_last ? DONE : RD0;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_start   <= 1'b0;
            r_start_d <= 1'b0;
            r_scale   <= '0;
            r_shift   <= '0;
            r_w0      <= '0;
            r_w1      <= '0;
        end else begin
            r_state   <= w_next;
            r_start   <= start;
            r_start_d <= r_start;
            if (w_launch) begin
                r_k     <= '0;
                r_scale <= scale;
                r_shift <= shift;
            end else if (r_state == WR && !w_last) begin
                r_k <= r_k + KW'(1);
            end
            if (r_state == RD1) r_w0 <= data_out_bar2;
            if (r_state == CAP) r_w1 <= data_out_bar2;
        end
    end

    assign done          = r_state == DONE;
    assign write_en_bar2 = 1'b0;
    assign data_in_bar2  = '0;
    assign addr_bar2     = (r_state == RD0) ? 32'({r_k, 1'b0}) :
                           (r_state == RD1) ? 32'({r_k, 1'b1}) : '0;
    assign write_en_bar3 = r_state == WR;
    assign addr_bar3     = (r_state == WR) ? 32'(r_k) : '0;
    assign data_in_bar3  = (r_state == WR) ? w_pack : '0;

`ifdef REQUANT_ROUND_EN
    assign w_rnd = (r_shift == 5'd0) ? '0 : (33'sd1 <<< (r_shift - 5'd1));
`else
    assign w_rnd = '0;
`endif

    // bytes 0..3 come from the even source word, 4..7 from the odd one
    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [15:0]        w_l;
        logic signed [32:0] w_p, w_s;
        assign w_l = (i < 4) ? r_w0[16*(i%4) +: 16] : r_w1[16*(i%4) +: 16];
        assign w_p = $signed({{17{w_l[15]}}, w_l}) * $signed({17'b0, r_scale});
        assign w_s = (w_p + w_rnd) >>> r_shift;
        assign w_pack[8*i +: 8] = (w_s > 33'sd127)  ? 8'h7f :
                                  (w_s < -33'sd128) ? 8'h80 : w_s[7:0];
    end
endmodule

// File: tb/tb_requant_pack.sv
// tb_requant_pack: random and directed passes checked against an arithmetic requantization model.
module tb_requant_pack;
    localparam int N = 64;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, done;
    logic [15:0] scale = '0;
    logic [4:0]  shift = '0;
    logic        write_en_bar2, write_en_bar3;
    logic [63:0] data_in_bar2, data_out_bar2, data_in_bar3;
    logic [63:0] data_out_bar3 = '0;
    logic [31:0] addr_bar2, addr_bar3;

    logic [63:0] src [2*N];
    logic [63:0] dst [N];
    logic [63:0] exp_mem [N];
    int n_cmp = 0, n_bad = 0, exp_k = 0;

    requant_pack #(.N_OUT_WORDS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .scale(scale), .shift(shift),
        .write_en_bar2(write_en_bar2), .data_in_bar2(data_in_bar2), .addr_bar2(addr_bar2),
        .data_out_bar2(data_out_bar2), .write_en_bar3(write_en_bar3), .data_in_bar3(data_in_bar3),
        .addr_bar3(addr_bar3), .data_out_bar3(data_out_bar3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_out_bar2 <= src[addr_bar2[6:0]];
        if (write_en_bar3) dst[addr_bar3[5:0]] <= data_in_bar3;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic logic [7:0] mq(input logic [15:0] l, input logic [15:0] sc, input logic [4:0] sh);
        longint a, b, p;
        logic [63:0] r;
        a = longint'($signed(l));
        b = longint'(sc);
        p = a * b;
`ifdef REQUANT_ROUND_EN
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
        p = p >>> sh;
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        r = p;
        return r[7:0];
    endfunction

    task automatic build_exp(input logic [15:0] sc, input logic [4:0] sh);
        logic [63:0] w, e;
        for (int k = 0; k < N; k++) begin
            for (int b = 0; b < 8; b++) begin
                w = (b < 4) ? src[2*k] : src[2*k+1];
                e[8*b +: 8] = mq(w[16*(b%4) +: 16], sc, sh);
            end
            exp_mem[k] = e;
            dst[k] = 64'hDEAD_BEEF_DEAD_BEEF;
        end
    endtask

    task automatic fill_const(input logic [63:0] w);
        for (int i = 0; i < 2*N; i++) src[i] = w;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 2*N; i++) src[i] = {$urandom, $urandom};
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_k = 0;
        end else begin
            chk("bar2_write", data_in_bar2 | 64'(write_en_bar2), 64'h0);
            if (write_en_bar3) begin
                if (exp_k >= N) begin
                    chk("extra_write", 64'(exp_k), 64'(N - 1));
                end else begin
                    chk("wr_addr", 64'(addr_bar3), 64'(exp_k));
                    chk("wr_data", data_in_bar3, exp_mem[exp_k]);
                end
                exp_k++;
            end
        end
    end

    task automatic check_dst(input string nm);
        int bad = 0;
        for (int k = 0; k < N; k++) if (dst[k] !== exp_mem[k]) bad++;
        chk(nm, 64'(bad), 64'h0);
        chk("write_count", 64'(exp_k), 64'(N));
    endtask

    task automatic run_pass(input logic [15:0] sc, input logic [4:0] sh, input int chg);
        bit was_done;
        int n, fell;
        start = 1'b0;
        repeat (3) @(negedge clk);
        was_done = done;
        scale = sc;
        shift = sh;
        build_exp(sc, sh);
        exp_k = 0;
        start = 1'b1;
        n = 0;
        fell = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == chg) begin
                scale = sc + 16'd1;
                shift = sh + 5'd1;
            end
            if (was_done && fell == 0 && !done) fell = n;
            if (done && (!was_done || fell != 0)) break;
        end
        chk("latency", 64'(n - 1), 64'(4*N + 1));
        if (was_done) chk("done_fall", 64'(fell - 1), 64'h1);
        @(negedge clk);
        check_dst("dst_words");
    endtask

    initial begin
        fill_const('0);
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_we3", 64'(write_en_bar3), 64'h0);
        chk("rst_addr2", 64'(addr_bar2), 64'h0);
        chk("rst_addr3", 64'(addr_bar3), 64'h0);
        chk("rst_din3", data_in_bar3, 64'h0);
        rst = 1'b0;

        fill_const({4{16'h0100}});
        run_pass(16'd1, 5'd2, 0);
        chk("lit_0100_w0", dst[0], 64'h4040404040404040);
        chk("lit_0100_w63", dst[N-1], 64'h4040404040404040);

        fill_const({16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF});
        run_pass(16'h0100, 5'd8, 0);
        chk("lit_sat", dst[5], 64'h807F807F807F807F);

        fill_const({16'hFFFD, 16'h0003, 16'hFFFD, 16'h0003});
        run_pass(16'd1, 5'd1, 0);
`ifdef REQUANT_ROUND_EN
        chk("lit_round", dst[7], 64'hFF02FF02FF02FF02);
`else
        chk("lit_trunc", dst[7], 64'hFE01FE01FE01FE01);
`endif

        fill_rand();
        run_pass(16'd1, 5'd0, 50);
        for (int t = 0; t < 3; t++) begin
            fill_rand();
            run_pass(16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)), 0);
        end
        fill_rand();
        run_pass(16'($urandom_range(1, 300)), 5'($urandom_range(0, 6)), 0);

        begin
            int n;
            start = 1'b0;
            repeat (3) @(negedge clk);
            fill_rand();
            build_exp(16'd7, 5'd3);
            scale = 16'd7;
            shift = 5'd3;
            exp_k = 0;
            start = 1'b1;
            repeat (100) @(posedge clk);
            #1 rst = 1'b1;
            fill_rand();
            scale = 16'd300;
            shift = 5'd5;
            build_exp(16'd300, 5'd5);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk("abort_done", 64'(done), 64'h0);
                chk("abort_we3", 64'(write_en_bar3), 64'h0);
            end
            rst = 1'b0;
            n = 0;
            while (n < 2000 && !done) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("relaunch_latency", 64'(n - 1), 64'(4*N + 1));
            @(negedge clk);
            check_dst("relaunch_dst");
        end

        fill_rand();
        run_pass(16'd2, 5'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/requant_pack.md
REQUANT_PACK -- requirements
Module: requant_pack

Interface
REQ-001 SHALL have parameter N_OUT_WORDS, default 64: number of packed output words; input words = 2*N_OUT_WORDS.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  rising edge launches one pass.
REQ-005 SHALL have port done  output  1  high when pass complete.
REQ-006 SHALL have port scale  input  16  unsigned multiplier.
REQ-007 SHALL have port shift  input  5  right-shift amount, 0..31.
REQ-008 SHALL have ports write_en_bar2 output 1, data_in_bar2 output 64, addr_bar2 output 32, data_out_bar2 input 64: source memory holding linear results.
REQ-009 SHALL have ports write_en_bar3 output 1, data_in_bar3 output 64, addr_bar3 output 32, data_out_bar3 input 64 (unused): destination memory.

Function
REQ-010 SHALL treat each source word as 4 signed 16-bit lanes; lane j = bits[16j+15:16j].
REQ-011 SHALL drive write_en_bar2=0 and data_in_bar2=0 at all times.
REQ-012 SHALL assume synchronous memories with 1-cycle read latency: data_out valid the cycle after addr is driven.
REQ-013 SHALL detect start rising edge via a registered copy of start; start held high is one launch only.
REQ-014 SHALL sample scale and shift at launch; later changes ignored until next launch.
REQ-015 SHALL implement FSM IDLE, RD0, RD1, CAP, WR, DONE.
REQ-016 IDLE->RD0 on start edge; RD0 drives addr_bar2=2k; RD1 captures word 2k and drives 2k+1; CAP captures word 2k+1; WR drives write_en_bar3=1, addr_bar3=k, packed data for one cycle.
REQ-017 WR->RD0 with k+1 if k<N_OUT_WORDS-1, else WR->DONE.
REQ-018 done SHALL be 1 only in DONE; DONE->RD0 (k=0) on next start rising edge; done falls the cycle that transition occurs.
REQ-019 Per lane: p = lane (s16) * {1'b0,scale} as signed 33-bit; optional rounding per REQ-026; arithmetic right shift by shift; saturate to [-128,127].
REQ-020 Output byte b (bits[8b+7:8b]) SHALL be lane b of word 2k for b<4, lane b-4 of word 2k+1 for b>=4.
REQ-021 write_en_bar3 SHALL be high exactly N_OUT_WORDS cycles per pass, never outside WR.
REQ-022 Pass latency: done rises 4*N_OUT_WORDS+1 rising edges after the edge that samples the start rise (257 for default).

Reset
REQ-023 On rst: state IDLE, k=0, done=0, all write_en=0, all addr=0, data_in_bar3=0, captured words 0, start-edge register 0.
REQ-024 Reset mid-pass SHALL abort immediately; no further destination writes; start held high after rst release SHALL launch a new pass.

Configuration
REQ-025 Macro REQUANT_ROUND_EN selects rounding.
REQ-026 Defined: add 2^(shift-1) to p before shift when shift>0 (round half up); undefined: plain truncating arithmetic shift.

Verification
REQ-027 All lanes 0x0100, scale=1, shift=2 -> all 64 dst words 0x4040404040404040; done after 257 edges.
REQ-028 Lanes 0x7FFF and 0x8000, scale=0x0100, shift=8 -> bytes 0x7F and 0x80 (saturation).
REQ-029 Lane 3 and lane -3, scale=1, shift=1 -> with REQUANT_ROUND_EN 0x02 / 0xFF; without 0x01 / 0xFE.
REQ-030 Assert rst at edge 100 of a pass -> done=0, write_en_bar3=0 next cycle onward; release with start high -> full pass rewrites all 64 words.
REQ-031 Change scale from 1 to 2 at edge 50 -> all outputs still computed with scale=1.
REQ-032 After done, start low then high -> done falls, second pass overwrites dst, done rises again after 257 edges.
